serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
Bit-serial adder controller that sequences a single one-bit half-adder-pair datapath to add two WIDTH-bit operands, one bit per clock, LSB first. It accepts a start request, captures the operands, steps the datapath WIDTH times with an internal carry flop, and then presents the result with a one-cycle done pulse. It is the sequencing layer that turns the combinational half-adder cell into a multi-bit arithmetic resource.

Parameters:
WIDTH, 8, operand and result width in bits (legal range: 2 or more).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request a new addition; sampled only in IDLE
a  input  WIDTH  operand A; captured on an accepted start
b  input  WIDTH  operand B; captured on an accepted start
busy  output  1  high while the serial operation is running
done  output  1  one-cycle pulse when sum and carry are updated
sum  output  WIDTH  registered result; holds until the next done or reset
carry  output  1  registered carry-out of the MSB; holds like sum

Behaviour:
- Clocking and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, carry=0. Operand shift registers, result shift register, carry flop and bit counter are all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a clock edge: load a and b into the shift registers, clear the carry flop and counter, go to RUN.
  - start=0: remain in IDLE.
- RUN: one datapath step per cycle, with x=A_reg[0], y=B_reg[0], cin=carry flop:
  - s1 = x^y, c1 = x&y (half adder 1).
  - s = s1^cin, c2 = s1&cin (half adder 2).
  - cout = c1|c2.
  - A_reg and B_reg shift right by 1. s shifts into the MSB of the result register. Carry flop <= cout. Counter increments.
  - When counter == WIDTH-1, the step in progress is the last one. At that edge: sum <= final result, carry <= cout, go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE unconditionally.
- busy is 1 only while in RUN.
- Latency: with start accepted at edge k, busy is high for cycles k+1 .. k+WIDTH, and done is high in cycle k+WIDTH+1.
- Throughput: with start held high continuously, one operation every WIDTH+2 cycles.
- start during RUN or DONE: ignored. No queuing.
- a and b changing after capture: no effect on the operation in progress.
- sum and carry are not cleared when a new operation starts. They change only together with done, or on reset.
- Arithmetic: {carry,sum} = a + b, modulo 2^(WIDTH+1). No signed interpretation.
- Reset asserted mid-operation: immediate abort. All outputs and state return to reset values, and no done is produced for the aborted operation.

Optional Feature:
Macro: SERIAL_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled together with start.
  - sub=1: B is captured inverted (~b) and the carry flop initialises to 1, giving sum = a - b mod 2^WIDTH.
  - In subtract mode, carry=1 means no borrow (a >= b unsigned).
  - sub=0: identical to the add behaviour.
- Not defined: the sub port does not exist, the carry flop always initialises to 0, and the block only adds.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with start=1 -> busy=0, done=0, sum=0x00, carry=0 throughout, and no operation starts.
2. Basic add: a=0x05, b=0x03, one-cycle start pulse -> busy=1 for exactly 8 cycles, then done=1 for 1 cycle with sum=0x08, carry=0; busy=0 in the done cycle.
3. Carry-out: a=0xFF, b=0x01 -> sum=0x00, carry=1. Then a=0x80, b=0x80 -> sum=0x00, carry=1. Then a=0x7F, b=0x01 -> sum=0x80, carry=0.
4. Back-to-back and operand isolation: start held high, first op a=0x12, b=0x34. Change a to 0xAA two cycles into RUN -> first done gives sum=0x46. The second op starts in the cycle after done; done pulses are spaced 10 cycles apart.
5. Reset mid-run: start a=0x0F, b=0x01, assert rst in the 4th RUN cycle -> busy, sum and carry go to 0 asynchronously and no done appears. After rst deasserts, a=0x21, b=0x21 -> sum=0x42, carry=0.
6. SERIAL_SUB_EN defined: a=0x10, b=0x01, sub=1 -> sum=0x0F, carry=1. Then a=0x01, b=0x02, sub=1 -> sum=0xFF, carry=0. Then a=0x05, b=0x03, sub=0 -> sum=0x08, carry=0.

Source files
------------

// File: rtl/serial_add_ctrl_if.sv
// Handshake/operand bundle for the bit-serial adder controller.
// Optional SERIAL_SUB_EN adds the sub request bit.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
`ifdef SERIAL_SUB_EN
    logic             sub;
`endif
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;

    modport master (
        output start,
`ifdef SERIAL_SUB_EN
        output sub,
`endif
        output a, b,
        input  busy, done, sum, carry
    );

    modport slave (
        input  start,
`ifdef SERIAL_SUB_EN
        input  sub,
`endif
        input  a, b,
        output busy, done, sum, carry
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: two chained half adders, one bit per clock, LSB first.
// Define SERIAL_SUB_EN to add a subtract mode (b inverted, carry-in forced to 1).
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_cy;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    logic             w_s1;
    logic             w_c1;
    logic             w_s;
    logic             w_c2;
    logic             w_cout;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;
    logic             w_sub;
    logic [WIDTH-1:0] w_b_load;

    // Datapath cell: half adder on the operand bits, second half adder folds in the carry.
    assign w_s1       = r_a[0] ^ r_b[0];
    assign w_c1       = r_a[0] & r_b[0];
    assign w_s        = w_s1 ^ r_cy;
    assign w_c2       = w_s1 & r_cy;
    assign w_cout     = w_c1 | w_c2;
    assign w_res_next = {w_s, r_res[WIDTH-1:1]};
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

`ifdef SERIAL_SUB_EN
    assign w_sub = bus.sub;
`else
    assign w_sub = 1'b0;
`endif
    assign w_b_load = w_sub ? ~bus.b : bus.b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cy    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= w_b_load;
                        r_cy    <= w_sub;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_next;
                    r_cy  <= w_cout;
                    r_cnt <= r_cnt + CW'(1);
                    // Last bit: publish the result on the same edge it is formed.
                    if (w_last) begin
                        r_sum   <= w_res_next;
                        r_carry <= w_cout;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.sum   = r_sum;
    assign bus.carry = r_carry;
endmodule
